// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: instruction sequencer for the 16-bit combinational ALU.
//
// Takes 16-bit instruction words over a valid/ready handshake. Operands come
// from an internal 8x16 register file. Each instruction goes through three
// steps:
//   1. Accept: latch the operands.
//   2. ISSUE (one cycle): present the operands and opcode to the ALU.
//   3. Writeback: capture the result into rd and the Z/S/C/V flags into the
//      flag register, then pulse done (and err for an illegal opcode).
//
// Instruction word:
//   [15:13] op   [12:10] rd   [9:7] rs1   [6:4] rs2   [3:0] unused
//   For LDI, [9:0] is an immediate that is zero-extended to 16 bits.
// Opcodes:
//   000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT (alu_b forced to 0)
//   110 LDI, 111 illegal
//
// Optional feature (macro ALU_SEQ_PIPE_EN):
//   instr_ready is also high in DONE. An instruction accepted in DONE goes
//   straight back to ISSUE, giving one instruction every two cycles.
//   Without the macro, instructions are accepted only in IDLE (one every
//   three cycles).
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   instr_valid/ready     instruction handshake
//   instr[15:0]           instruction word
//   alu_op/alu_a/alu_b    registered opcode and operands to the ALU
//   alu_result, alu_z/s/c/v  ALU result and flags
//   flags[3:0]            registered {Z,S,C,V}
//   done, err             one-cycle retire pulse; err marks an illegal opcode
//   dbg_addr, dbg_data    combinational register-file read port
module alu_seq_ctrl #(
    parameter int unsigned NREG = 8,
    parameter int unsigned IMMW = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    input  logic        alu_z,
    input  logic        alu_s,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic [3:0]  flags,
    output logic        done,
    output logic        err,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 3;
    localparam int unsigned AW  = 3;
    localparam int unsigned FW  = 4;

    localparam logic [OPW-1:0] OP_NOT = 3'b101;
    localparam logic [OPW-1:0] OP_LDI = 3'b110;
    localparam logic [OPW-1:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Latched instruction context; op and operands double as the ALU outputs.
    logic [OPW-1:0]  alu_op_q;
    logic [DW-1:0]   alu_a_q;
    logic [DW-1:0]   alu_b_q;
    logic [AW-1:0]   rd_q;
    logic [IMMW-1:0] imm_q;

    logic [FW-1:0]   flags_q;
    logic            done_q;
    logic            err_q;
    logic [DW-1:0]   rf_q [NREG];

    logic            ready_c;
    logic            accept_c;
    logic            wb_en_c;
    logic            flag_en_c;
    logic [DW-1:0]   wb_data_c;

    // Instruction field decode.
    logic [OPW-1:0]  dec_op;
    logic [AW-1:0]   dec_rd;
    logic [AW-1:0]   dec_rs1;
    logic [AW-1:0]   dec_rs2;
    logic [IMMW-1:0] dec_imm;

    assign dec_op  = instr[15:13];
    assign dec_rd  = instr[12:10];
    assign dec_rs1 = instr[9:7];
    assign dec_rs2 = instr[6:4];
    assign dec_imm = instr[IMMW-1:0];

    // Acceptance window.
`ifdef ALU_SEQ_PIPE_EN
    assign ready_c = (state_q == S_IDLE) || (state_q == S_DONE);
`else
    assign ready_c = (state_q == S_IDLE);
`endif

    // Ready is suppressed while reset is held so nothing is accepted mid-reset.
    assign instr_ready = ready_c & ~rst;
    assign accept_c    = instr_ready & instr_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and writeback decode.
    always_comb begin
        state_d   = state_q;
        wb_en_c   = 1'b0;
        flag_en_c = 1'b0;
        wb_data_c = alu_result;
        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d   = S_DONE;
                // ALU ops and LDI write rd; only ALU ops update the flags.
                wb_en_c   = (alu_op_q != OP_ILL);
                flag_en_c = (alu_op_q <= OP_NOT);
                if (alu_op_q == OP_LDI) begin
                    wb_data_c = DW'(imm_q);
                end
            end
            S_DONE: begin
                state_d = accept_c ? S_ISSUE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand capture at acceptance. In pipelined mode an acceptance in DONE
    // already sees the previous writeback, which landed at the end of ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
        end else if (accept_c) begin
            alu_op_q <= dec_op;
            alu_a_q  <= rf_q[dec_rs1];
            alu_b_q  <= (dec_op == OP_NOT) ? '0 : rf_q[dec_rs2];
            rd_q     <= dec_rd;
            imm_q    <= dec_imm;
        end
    end

    // Register file; reset discards any in-flight writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en_c) begin
            rf_q[rd_q] <= wb_data_c;
        end
    end

    // Flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (flag_en_c) begin
            flags_q <= {alu_z, alu_s, alu_c, alu_v};
        end
    end

    // Retire pulses, raised for the cycle following ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (state_q == S_ISSUE);
            err_q  <= (state_q == S_ISSUE) && (alu_op_q == OP_ILL);
        end
    end

    assign alu_op   = alu_op_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign flags    = flags_q;
    assign done     = done_q;
    assign err      = err_q;
    assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl.
// Contents:
//   - A behavioural ALU drives the DUT's ALU inputs.
//   - An ISA-level model predicts each instruction at acceptance and queues
//     the expected operands, flags and err.
//   - A monitor checks ISSUE operands and retire behaviour against the queue.
module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_PIPE_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        alu_z, alu_s, alu_c, alu_v;
    logic [3:0]  flags;
    logic        done;
    logic        err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    alu_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_z       (alu_z),
        .alu_s       (alu_s),
        .alu_c       (alu_c),
        .alu_v       (alu_v),
        .flags       (flags),
        .done        (done),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {result, Z, S, C, V}; C is carry for ADD, borrow for SUB.
    function automatic logic [19:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] r;
        logic        c;
        logic        v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[15:0]; c = w[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'd1: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[15:0]; c = w[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            default: r = '0;
        endcase
        return {r, (r == 16'h0), r[15], c, v};
    endfunction

    logic [19:0] alu_out;
    always_comb alu_out = alu_fn(alu_op, alu_a, alu_b);
    assign alu_result = alu_out[19:4];
    assign alu_z      = alu_out[3];
    assign alu_s      = alu_out[2];
    assign alu_c      = alu_out[1];
    assign alu_v      = alu_out[0];

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fl;
        logic        er;
        int          acc;
    } sb_t;

    sb_t         sbq[$];
    int          acc_log[$];
    logic [15:0] m_regs [8];
    logic [3:0]  m_flags;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Acceptance side: update the model and push the expectation.
    always @(posedge clk) begin
        sb_t         e;
        logic [2:0]  op;
        logic [19:0] r;
        cyc = cyc + 1;
        if (rst) begin
            sbq.delete();
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            m_flags = '0;
        end else if (instr_valid && instr_ready) begin
            op    = instr[15:13];
            e.op  = op;
            e.a   = m_regs[instr[9:7]];
            e.b   = (op == 3'd5) ? 16'h0 : m_regs[instr[6:4]];
            e.er  = (op == 3'd7);
            e.acc = cyc;
            if (op <= 3'd5) begin
                r = alu_fn(op, e.a, e.b);
                m_regs[instr[12:10]] = r[19:4];
                m_flags = r[3:0];
            end else if (op == 3'd6) begin
                m_regs[instr[12:10]] = {6'b0, instr[9:0]};
            end
            e.fl = m_flags;
            sbq.push_back(e);
            acc_log.push_back(cyc);
        end
    end

    // Output side: ISSUE operands and retire pulses.
    always @(negedge clk) begin
        sb_t e;
        if (done) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", 32'(done), 32'(0));
            end else begin
                e = sbq.pop_front();
                chk("done_latency", 32'(cyc + 1 - e.acc), 32'(2));
                chk("err", 32'(err), 32'(e.er));
                chk("flags_at_done", 32'(flags), 32'(e.fl));
            end
        end else if (sbq.size() != 0 && sbq[0].acc == cyc) begin
            chk("issue_op", 32'(alu_op), 32'(sbq[0].op));
            chk("issue_a", 32'(alu_a), 32'(sbq[0].a));
            chk("issue_b", 32'(alu_b), 32'(sbq[0].b));
        end
    end

    task automatic check_regs(input string tag);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            chk($sformatf("%s_r%0d", tag, r), 32'(dbg_data), 32'(m_regs[r]));
        end
    endtask

    task automatic check_reg(input string tag, input int r, input logic [15:0] exp);
        dbg_addr = 3'(r);
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("accept_timeout", 32'(instr_ready), 32'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && sbq.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain", 32'(sbq.size()), 32'(0));
    endtask

    task automatic send(input logic [15:0] w);
        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        drain();
    endtask

    logic [15:0] stream [4];

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        stream[0] = 16'h0CA0;   // r3 = r1 + r2
        stream[1] = 16'h1190;   // r4 = r3 + r1
        stream[2] = 16'h1630;   // r5 = r4 + r3
        stream[3] = 16'h06D0;   // r1 = r5 + r5

        // Reset state.
        repeat (3) @(negedge clk);
        chk("ready_in_rst", 32'(instr_ready), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_flags", 32'(flags), 32'(0));
        chk("rst_alu_op", 32'(alu_op), 32'(0));
        chk("rst_alu_a", 32'(alu_a), 32'(0));
        chk("rst_alu_b", 32'(alu_b), 32'(0));
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(instr_ready), 32'(1));
        check_regs("rst");

        // LDI, LDI, ADD.
        send(16'hC7FF);
        check_reg("ldi_r1", 1, 16'h03FF);
        chk("ldi_flags", 32'(flags), 32'(4'b0000));
        send(16'hC801);
        check_reg("ldi_r2", 2, 16'h0001);
        chk("ldi2_flags", 32'(flags), 32'(4'b0000));
        send(16'h0CA0);
        check_reg("add_r3", 3, 16'h0400);
        chk("add_flags", 32'(flags), 32'(4'b0000));

        // NOT, then ADD wrapping to zero.
        send(16'hB000);
        check_reg("not_r4", 4, 16'hFFFF);
        chk("not_flags", 32'(flags), 32'(4'b0100));
        send(16'h1620);
        check_reg("add_r5", 5, 16'h0000);
        chk("add_wrap_flags", 32'(flags), 32'(4'b1010));

        // SUB with borrow.
        send(16'h3820);
        check_reg("sub_r6", 6, 16'hFFFF);
        chk("sub_flags", 32'(flags), 32'(4'b0110));

        // Illegal opcode.
        send(16'hE000);
        check_regs("ill");
        chk("ill_flags", 32'(flags), 32'(4'b0110));

        // Reset during ISSUE.
        @(negedge clk);
        instr       = 16'h0CA0;
        instr_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_midrst", 32'(instr_ready), 32'(1));
        check_reg("midrst_r3", 3, 16'h0000);
        chk("midrst_flags", 32'(flags), 32'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("midrst_no_done", 32'(done), 32'(0));
        end

        // Back-to-back stream with instr_valid held high.
        send(16'hC405);
        send(16'hC807);
        acc_log.delete();
        @(negedge clk);
        instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = stream[i];
            wait_ready();
            @(posedge clk);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        drain();
        chk("stream_accepts", 32'(acc_log.size()), 32'(4));
        for (int i = 1; i < acc_log.size(); i++) begin
            chk($sformatf("accept_gap%0d", i), 32'(acc_log[i] - acc_log[i-1]), 32'(GAP));
        end
        check_reg("stream_r1", 1, 16'h003A);
        check_reg("stream_r3", 3, 16'h000C);
        check_reg("stream_r4", 4, 16'h0011);
        check_reg("stream_r5", 5, 16'h001D);
        check_regs("stream");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
